// File: rtl/rrb_pkg.sv
// rtl/rrb_pkg.sv - shared slot sizing, slot-tag type and mdata pack/unpack helpers
// Ports: none (package).
package rrb_pkg;

  localparam int TAG_W   = 5;
  localparam int DEPTH   = 2 ** TAG_W;
  localparam int MDATA_W = 14;

  typedef logic [TAG_W-1:0] slot_t;

  // CCI-side mdata carries the slot index zero-extended.
  function automatic logic [MDATA_W-1:0] pack_mdata(input slot_t s);
    return {{(MDATA_W - TAG_W){1'b0}}, s};
  endfunction

  // Only the low TAG_W bits of a returning CCI tag identify the slot.
  function automatic slot_t unpack_slot(input logic [MDATA_W-1:0] m);
    return m[TAG_W-1:0];
  endfunction

endpackage

// File: rtl/read_reorder_buffer_if.sv
// rtl/read_reorder_buffer_if.sv - user-side and CCI-side read bus bundle
// Ports: user request/response signals and CCI request/response signals.
//   slave  : the reorder buffer's view
//   master : the environment's view (user + CCI)
interface read_reorder_buffer_if #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512
);

  logic [ADDR_LMT-1:0]    usr_rd_req_addr;
  logic [MDATA-1:0]       usr_rd_req_mdata;
  logic                   usr_rd_req_en;
  logic                   usr_rd_req_almostfull;
  logic                   usr_rd_rsp_valid;
  logic [MDATA-1:0]       usr_rd_rsp_mdata;
  logic [CACHE_WIDTH-1:0] usr_rd_rsp_data;

  logic [ADDR_LMT-1:0]    rd_req_addr;
  logic [MDATA-1:0]       rd_req_mdata;
  logic                   rd_req_en;
  logic                   rd_req_almostfull;
  logic                   rd_rsp_valid;
  logic [MDATA-1:0]       rd_rsp_mdata;
  logic [CACHE_WIDTH-1:0] rd_rsp_data;

  modport slave (
    input  usr_rd_req_addr, usr_rd_req_mdata, usr_rd_req_en,
    output usr_rd_req_almostfull, usr_rd_rsp_valid, usr_rd_rsp_mdata, usr_rd_rsp_data,
    output rd_req_addr, rd_req_mdata, rd_req_en,
    input  rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data
  );

  modport master (
    output usr_rd_req_addr, usr_rd_req_mdata, usr_rd_req_en,
    input  usr_rd_req_almostfull, usr_rd_rsp_valid, usr_rd_rsp_mdata, usr_rd_rsp_data,
    input  rd_req_addr, rd_req_mdata, rd_req_en,
    output rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data
  );

endinterface

// File: rtl/rrb_ram.sv
// rtl/rrb_ram.sv - simple dual-port line RAM, one write port, one registered read port
// Ports: clk, reset_n (clears read register only), we/waddr/wdata, re/raddr, rdata.
module rrb_ram #(
  parameter int WIDTH  = 512,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds the last drained line between drains.
  always_ff @(posedge clk) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/read_reorder_buffer.sv
// rtl/read_reorder_buffer.sv - tags user reads with slot indices and returns CCI responses in request order
// Ports: clk, reset_n (sync active-low), bus (read_reorder_buffer_if.slave), err (sticky protocol error).
module read_reorder_buffer
  import rrb_pkg::*;
#(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int AF_MARGIN   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  read_reorder_buffer_if.slave bus,
  output logic                 err
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);
  localparam logic [TAG_W:0] AF_CNT   = (TAG_W + 1)'(AF_MARGIN);

  logic [MDATA-1:0]    tag_mem [DEPTH];
  logic [DEPTH-1:0]    alloc;
  logic [DEPTH-1:0]    valid;
  slot_t               head;
  slot_t               tail;
  logic [TAG_W:0]      count;

  logic                full;
  logic                accept;
  logic                drain;
  logic                rsp_ok;
  slot_t               rsp_slot;
  logic [ADDR_LMT-1:0] req_addr;

  assign req_addr = bus.usr_rd_req_addr;
  assign rsp_slot = unpack_slot(MDATA_W'(bus.rd_rsp_mdata));
  assign full     = (count == FULL_CNT);
  // Full test uses the pre-drain count, so a drain in the same cycle does not open a slot.
  assign accept   = bus.usr_rd_req_en && !full;
  assign drain    = valid[head];
  assign rsp_ok   = bus.rd_rsp_valid && alloc[rsp_slot] && !valid[rsp_slot];

  assign bus.usr_rd_req_almostfull = ((FULL_CNT - count) <= AF_CNT) || bus.rd_req_almostfull;

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tail] <= bus.usr_rd_req_mdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      alloc                <= '0;
      valid                <= '0;
      err                  <= 1'b0;
      bus.rd_req_en        <= 1'b0;
      bus.rd_req_addr      <= '0;
      bus.rd_req_mdata     <= '0;
      bus.usr_rd_rsp_valid <= 1'b0;
      bus.usr_rd_rsp_mdata <= '0;
    end else begin
      bus.rd_req_en        <= accept;
      bus.usr_rd_rsp_valid <= drain;

      if (accept) begin
        bus.rd_req_addr  <= req_addr;
        bus.rd_req_mdata <= MDATA'(pack_mdata(tail));
        alloc[tail]      <= 1'b1;
        tail             <= tail + 1'b1;
      end

      // rsp_ok requires valid==0 and drain requires valid==1, so these never hit the same slot.
      if (rsp_ok) valid[rsp_slot] <= 1'b1;

      if (drain) begin
        bus.usr_rd_rsp_mdata <= tag_mem[head];
        alloc[head]          <= 1'b0;
        valid[head]          <= 1'b0;
        head                 <= head + 1'b1;
      end

      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if ((bus.usr_rd_req_en && full) || (bus.rd_rsp_valid && !rsp_ok)) err <= 1'b1;
    end
  end

  rrb_ram #(
    .WIDTH  (CACHE_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (TAG_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (rsp_ok),
    .waddr   (rsp_slot),
    .wdata   (bus.rd_rsp_data),
    .re      (drain),
    .raddr   (head),
    .rdata   (bus.usr_rd_rsp_data)
  );

endmodule

// File: tb/tb_read_reorder_buffer.sv
// tb/tb_read_reorder_buffer.sv - directed self-checking bench for read_reorder_buffer
module tb_read_reorder_buffer;

  localparam int ADDR_LMT = 20;
  localparam int MDATA    = 14;
  localparam int CW       = 512;

  logic clk;
  logic reset_n;
  logic err;
  int   total = 0;
  int   bad   = 0;
  int   exp_n;
  int   wbase;
  int   perm [20];

  read_reorder_buffer_if #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW)) bus ();

  read_reorder_buffer #(
    .ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW), .AF_MARGIN(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW-1:0] mk(input int id);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ id;
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.usr_rd_req_en = 0;
    bus.rd_rsp_valid  = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic drive_rsp(input int slot, input logic [CW-1:0] d);
    bus.rd_rsp_valid = 1;
    bus.rd_rsp_mdata = 14'(slot);
    bus.rd_rsp_data  = d;
  endtask

  task automatic wrap_sample();
    if (bus.usr_rd_rsp_valid === 1'b1) begin
      chk("wrap_mdata", bus.usr_rd_rsp_mdata, 'h100 + wbase + exp_n);
      chk_data("wrap_data", bus.usr_rd_rsp_data, mk('h200 + wbase + exp_n));
      exp_n++;
    end
  endtask

  initial begin
    reset_n = 0;
    bus.usr_rd_req_en = 0; bus.usr_rd_req_addr = 0; bus.usr_rd_req_mdata = 0;
    bus.rd_req_almostfull = 0; bus.rd_rsp_valid = 0; bus.rd_rsp_mdata = 0; bus.rd_rsp_data = 0;
    tick(); tick();
    reset_n = 1;

    // reset state
    chk("rst_req_en", bus.rd_req_en, 0);
    chk("rst_req_addr", bus.rd_req_addr, 0);
    chk("rst_req_mdata", bus.rd_req_mdata, 0);
    chk("rst_rsp_valid", bus.usr_rd_rsp_valid, 0);
    chk("rst_rsp_mdata", bus.usr_rd_rsp_mdata, 0);
    chk_data("rst_rsp_data", bus.usr_rd_rsp_data, '0);
    chk("rst_err", err, 0);
    chk("rst_af", bus.usr_rd_req_almostfull, 0);
    chk("rst_count", dut.count, 0);

    // in-order echo
    for (int i = 0; i < 4; i++) begin
      bus.usr_rd_req_en = 1; bus.usr_rd_req_addr = 20'(16 + i); bus.usr_rd_req_mdata = 14'(10 + i);
      tick();
      chk("echo_req_en", bus.rd_req_en, 1);
      chk("echo_req_addr", bus.rd_req_addr, 16 + i);
      chk("echo_req_tag", bus.rd_req_mdata, i);
    end
    bus.usr_rd_req_en = 0;
    tick();
    chk("echo_req_idle", bus.rd_req_en, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive_rsp(k, mk(k)); else bus.rd_rsp_valid = 0;
      tick();
      if (k >= 1 && k <= 4) begin
        chk("echo_rsp_valid", bus.usr_rd_rsp_valid, 1);
        chk("echo_rsp_mdata", bus.usr_rd_rsp_mdata, 10 + k - 1);
        chk_data("echo_rsp_data", bus.usr_rd_rsp_data, mk(k - 1));
      end else begin
        chk("echo_rsp_idle", bus.usr_rd_rsp_valid, 0);
      end
    end

    // reverse-order completion
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.usr_rd_req_en = 1; bus.usr_rd_req_addr = 20'(i); bus.usr_rd_req_mdata = 14'('h20 + i);
      tick();
      chk("rev_req_tag", bus.rd_req_mdata, i);
    end
    bus.usr_rd_req_en = 0;
    for (int k = 0; k < 8; k++) begin
      drive_rsp(7 - k, mk('h40 + 7 - k));
      tick();
      chk("rev_hold", bus.usr_rd_rsp_valid, 0);
    end
    bus.rd_rsp_valid = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("rev_valid", bus.usr_rd_rsp_valid, 1);
      chk("rev_mdata", bus.usr_rd_rsp_mdata, 'h20 + j);
      chk_data("rev_data", bus.usr_rd_rsp_data, mk('h40 + j));
    end
    tick();
    chk("rev_done", bus.usr_rd_rsp_valid, 0);

    // fill to 32, overflow, then drain
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bus.usr_rd_req_en = 1; bus.usr_rd_req_addr = 20'(i); bus.usr_rd_req_mdata = 14'('h40 + i);
      #1;
      chk("full_af", bus.usr_rd_req_almostfull, (i >= 28) ? 1 : 0);
      tick();
      chk("full_req_en", bus.rd_req_en, 1);
      chk("full_req_tag", bus.rd_req_mdata, i);
    end
    chk("full_af_32", bus.usr_rd_req_almostfull, 1);
    chk("full_count", dut.count, 32);
    bus.usr_rd_req_mdata = 14'h3FF;
    tick();
    chk("ovf_req_en", bus.rd_req_en, 0);
    chk("ovf_err", err, 1);
    chk("ovf_count", dut.count, 32);
    bus.usr_rd_req_en = 0;
    for (int k = 0; k < 34; k++) begin
      if (k < 32) drive_rsp(k, mk('h80 + k)); else bus.rd_rsp_valid = 0;
      tick();
      if (k >= 1 && k <= 32) begin
        chk("full_rsp_valid", bus.usr_rd_rsp_valid, 1);
        chk("full_rsp_mdata", bus.usr_rd_rsp_mdata, 'h40 + k - 1);
        chk_data("full_rsp_data", bus.usr_rd_rsp_data, mk('h80 + k - 1));
      end else begin
        chk("full_rsp_idle", bus.usr_rd_rsp_valid, 0);
      end
    end
    chk("full_count_end", dut.count, 0);
    chk("full_af_end", bus.usr_rd_req_almostfull, 0);

    // wrap with random permutations
    do_reset();
    for (int r = 0; r < 3; r++) begin
      wbase = r * 20;
      for (int i = 0; i < 20; i++) begin
        bus.usr_rd_req_en = 1; bus.usr_rd_req_addr = 20'(wbase + i); bus.usr_rd_req_mdata = 14'('h100 + wbase + i);
        tick();
        chk("wrap_req_tag", bus.rd_req_mdata, (wbase + i) % 32);
      end
      bus.usr_rd_req_en = 0;
      for (int i = 0; i < 20; i++) perm[i] = i;
      for (int i = 19; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(i, 0));
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      exp_n = 0;
      for (int i = 0; i < 20; i++) begin
        drive_rsp((wbase + perm[i]) % 32, mk('h200 + wbase + perm[i]));
        tick();
        wrap_sample();
      end
      bus.rd_rsp_valid = 0;
      for (int w = 0; w < 40 && exp_n < 20; w++) begin
        tick();
        wrap_sample();
      end
      chk("wrap_returned", exp_n, 20);
    end
    chk("wrap_err", err, 0);
    chk("wrap_count", dut.count, 0);

    // CCI back-pressure
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.usr_rd_req_en = 1; bus.usr_rd_req_addr = 20'(i); bus.usr_rd_req_mdata = 14'('h50 + i);
      tick();
    end
    bus.usr_rd_req_en = 0;
    #1;
    chk("bp_af_low", bus.usr_rd_req_almostfull, 0);
    bus.rd_req_almostfull = 1;
    bus.usr_rd_req_en = 1; bus.usr_rd_req_addr = 20'h77; bus.usr_rd_req_mdata = 14'h52;
    #1;
    chk("bp_af_high", bus.usr_rd_req_almostfull, 1);
    tick();
    chk("bp_req_en", bus.rd_req_en, 1);
    chk("bp_req_tag", bus.rd_req_mdata, 2);
    chk("bp_req_addr", bus.rd_req_addr, 'h77);
    bus.rd_req_almostfull = 0;
    bus.usr_rd_req_en = 0;
    #1;
    chk("bp_af_release", bus.usr_rd_req_almostfull, 0);

    // reset with 5 outstanding
    for (int i = 0; i < 2; i++) begin
      bus.usr_rd_req_en = 1; bus.usr_rd_req_addr = 20'(i); bus.usr_rd_req_mdata = 14'('h53 + i);
      tick();
    end
    bus.usr_rd_req_en = 0;
    tick();
    chk("mid_count", dut.count, 5);
    do_reset();
    chk("mid_rst_count", dut.count, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_req_en", bus.rd_req_en, 0);
    drive_rsp(2, mk('h99));
    tick();
    bus.rd_rsp_valid = 0;
    chk("mid_err", err, 1);
    chk("mid_no_rsp0", bus.usr_rd_rsp_valid, 0);
    tick();
    chk("mid_no_rsp1", bus.usr_rd_rsp_valid, 0);
    tick();
    chk("mid_no_rsp2", bus.usr_rd_rsp_valid, 0);
    chk("mid_count_end", dut.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_reorder_buffer.md
Name: read_reorder_buffer

Overview:
- Sits between the matrix-multiply read port and the CCI read channel, upstream of the compute core on the read path.
- Tags each user read request with a slot index carried in CCI mdata and stores out-of-order responses by slot.
- Returns line data to the user strictly in request order, along with the user's original mdata.
- Generates back-pressure toward the user from its own occupancy and from CCI almostfull.

Parameters:
- ADDR_LMT, 20, cache-line address width.
- MDATA, 14, mdata width on both the user and CCI sides.
- CACHE_WIDTH, 512, line width in bits.
- TAG_W, 5, slot index width; DEPTH = 2**TAG_W = 32 slots. TAG_W <= MDATA.
- AF_MARGIN, 4, free-slot threshold for almostfull.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- usr_rd_req_addr  in  ADDR_LMT  user read address
- usr_rd_req_mdata  in  MDATA  user tag, returned with the data
- usr_rd_req_en  in  1  user request strobe
- usr_rd_req_almostfull  out  1  user must stop issuing
- usr_rd_rsp_valid  out  1  in-order response strobe
- usr_rd_rsp_mdata  out  MDATA  user tag of the response
- usr_rd_rsp_data  out  CACHE_WIDTH  line data
- rd_req_addr  out  ADDR_LMT  CCI read address
- rd_req_mdata  out  MDATA  {zeros, slot tag}
- rd_req_en  out  1  CCI request strobe
- rd_req_almostfull  in  1  CCI back-pressure
- rd_rsp_valid  in  1  CCI response strobe
- rd_rsp_mdata  in  MDATA  CCI response tag; low TAG_W bits are the slot
- rd_rsp_data  in  CACHE_WIDTH  CCI response data
- err  out  1  sticky protocol-error flag

Behaviour:
Reset:
- Synchronous, active when reset_n == 0 at a clk edge.
- Clears head, tail, occupancy count, all slot alloc/valid bits, err, rd_req_en and usr_rd_rsp_valid.
- rd_req_addr, rd_req_mdata and usr_rd_rsp_* are 0 after reset.
- Reset mid-operation discards every outstanding slot. Later CCI responses to those tags are treated as unallocated (see Errors).

Request path:
- Accept on usr_rd_req_en while count < DEPTH.
- On accept: store usr mdata in tag array[tail], set alloc[tail], and register the request to CCI:
  - rd_req_en = 1 on the next cycle;
  - rd_req_mdata = zero-extended tail;
  - tail increments modulo DEPTH.
- Request latency is exactly 1 cycle.
- Requests are forwarded even while rd_req_almostfull is high; CCI tolerates the in-flight skid.

Almostfull:
- usr_rd_req_almostfull is combinational: (DEPTH - count) <= AF_MARGIN, OR rd_req_almostfull.

Response capture:
- On rd_rsp_valid with slot s = rd_rsp_mdata[TAG_W-1:0] and alloc[s] = 1 and valid[s] = 0: write data RAM[s] and set valid[s].

Drain:
- Each cycle, if valid[head] = 1: read RAM[head] and tag[head], then clear alloc/valid[head] and increment head.
- The read is registered, so usr_rd_rsp_valid pulses the next cycle with data and mdata.
- Back-to-back drains, one per cycle, are required.
- Minimum latency from rd_rsp_valid to usr_rd_rsp_valid is 2 cycles.
- There is no user ready signal; the consumer must always accept.

Count:
- +1 on accept, -1 on drain, unchanged when both happen in the same cycle.
- Wrap-around of head/tail is natural modulo DEPTH. count disambiguates full (DEPTH) from empty (0).

Simultaneous events:
- A response write to slot s and a drain of a different slot in the same cycle both proceed.
- A response to slot == head is visible to drain the following cycle.
- A request that allocates a slot freed by a drain in the same cycle is legal: the drained slot is head and the allocated slot is tail. When count == DEPTH the accept condition is evaluated before the decrement, so the request is rejected.

Errors (set err sticky until reset; offending event otherwise ignored):
- usr_rd_req_en while count == DEPTH: request dropped.
- rd_rsp_valid to a slot with alloc == 0, or with valid already 1: response dropped.

Decomposition:
- Shared package rrb_pkg: DEPTH, TAG_W defaults, slot-tag type, the mdata pack/unpack function (zero-extend tag / extract low TAG_W bits).
- One sub-module, rrb_ram: simple dual-port DEPTH x CACHE_WIDTH RAM with one write port and one registered read port, inferable as block RAM.
- The tag array, alloc/valid bits and pointers stay in the top module.

Test Plan:
- In-order echo: 4 requests, addr 0x10..0x13, mdata 0xA..0xD; CCI responds in order 3 cycles later -> usr_rd_rsp at mdata 0xA..0xD, data matches, each 2 cycles after its rd_rsp_valid.
- Reverse order: 8 requests with tags 0..7; CCI returns tags 7..0 one per cycle -> no usr_rd_rsp until tag 0 arrives, then 8 consecutive-cycle responses in original order.
- Full: 32 requests with no responses -> almostfull high once count reaches 28. A 33rd usr_rd_req_en -> not forwarded to CCI, err = 1. Then 32 responses -> 32 drains, count 0.
- Wrap: 3 rounds of 20 requests, each round answered with a random permutation -> tags wrap past 31 to 0, all 60 returned in order, err stays 0.
- CCI back-pressure: rd_req_almostfull = 1 with count = 2 -> usr_rd_req_almostfull = 1 in the same cycle. A request issued in that cycle is still forwarded on the next cycle.
- Reset mid-flight: 5 outstanding requests, reset_n low for 1 cycle, then a CCI response on tag 2 -> no usr_rd_rsp, err = 1, count = 0.
